// File: rtl/mips_mem_sys.sv
// Word RAM plus MMIO window (byte TX FIFO, status, cycle counter) behind the multicycle MIPS core.
// Reads are combinational; writes land on clk rise. MEMSYS_CYCLE_CNT_EN enables the CYCLE counter.
module mips_mem_sys #(
    parameter int          MEM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram_q [MEM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_rd;

    logic          mmio_hit, tx_hit, st_hit, cyc_hit;
    logic          full, empty, pop, push, drop;
    logic [AW-1:0] ram_idx;
    logic [1:0]    unused_addr_lsbs;

    assign unused_addr_lsbs = addr[1:0];
    assign mmio_hit = (addr[31:8] == MMIO_BASE[31:8]);
    assign tx_hit   = mmio_hit && (addr[7:2] == 6'h00);
    assign st_hit   = mmio_hit && (addr[7:2] == 6'h01);
    assign cyc_hit  = mmio_hit && (addr[7:2] == 6'h02);
    assign ram_idx  = addr[AW+1:2];

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo_q[rd_ptr_q];
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push     = memwrite && tx_hit && (!full || pop);
    assign drop     = memwrite && tx_hit && full && !pop;

    always_ff @(posedge clk) begin
        if (memwrite && !mmio_hit) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (memwrite && st_hit && writedata[11]) ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push) fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end

`ifdef MEMSYS_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    assign cycle_d  = (memwrite && cyc_hit) ? writedata : cycle_q + 32'd1;
    assign cycle_rd = cycle_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_d;
    end
`else
    assign cycle_rd = 32'h0;
`endif

    always_comb begin
        readdata = 32'h0;
        if (!mmio_hit)     readdata = ram_q[ram_idx];
        else if (st_hit)   readdata = {20'h0, ovf_q, full, empty, 1'b0, 8'(count_q)};
        else if (cyc_hit)  readdata = cycle_rd;
    end
endmodule

// File: tb/tb_mips_mem_sys.sv
// Directed bench for mips_mem_sys: RAM alias, FIFO order/overflow, CYCLE wrap, reset behaviour.
module tb_mips_mem_sys;
    localparam logic [31:0] TXD = 32'hFFFF_FF00;
    localparam logic [31:0] STS = 32'hFFFF_FF04;
    localparam logic [31:0] CYC = 32'hFFFF_FF08;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        memwrite = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    mips_mem_sys dut (
        .clk(clk), .reset(reset), .addr(addr), .memwrite(memwrite),
        .writedata(writedata), .readdata(readdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write per cycle; returns 1 time unit after the capturing edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; writedata = d; memwrite = 1'b1;
        @(posedge clk); #1;
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a; #1;
        v = readdata;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [31:0] v;
    logic [31:0] exp_cyc;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        step();

        // reset state
        rd(STS, v);               chk("rst_status", v, 32'h200);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        rd(TXD, v);               chk("txdata_reads_0", v, 32'h0);
        rd(32'hFFFF_FF0C, v);     chk("unmapped_reads_0", v, 32'h0);

        // test 1: RAM and alias
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, v);            chk("ram_rd", v, 32'hDEAD_BEEF);
        rd(32'h110, v);           chk("ram_alias", v, 32'hDEAD_BEEF);
        rd(32'h13, v);            chk("ram_lsb_ignored", v, 32'hDEAD_BEEF);
        wr(32'h20, 32'h1111_1111);
        addr = 32'h20; writedata = 32'h2222_2222; memwrite = 1'b1; #1;
        chk("ram_old_data_same_cycle", readdata, 32'h1111_1111);
        @(posedge clk); #1; memwrite = 1'b0;
        rd(32'h20, v);            chk("ram_new_data", v, 32'h2222_2222);

        // test 2: FIFO order
        tx_ready = 1'b0;
        wr(TXD, 32'h41); wr(TXD, 32'h42); wr(TXD, 32'h43);
        rd(STS, v);               chk("fifo_status3", v, 32'h003);
        chk("fifo_head", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1; #1;
        chk("drain0", {24'b0, tx_data}, 32'h41);
        step();                   chk("drain1", {24'b0, tx_data}, 32'h42);
        step();                   chk("drain2", {24'b0, tx_data}, 32'h43);
        step();                   chk("drained_valid", {31'b0, tx_valid}, 32'h0);
        rd(STS, v);               chk("drained_status", v, 32'h200);
        tx_ready = 1'b0;

        // test 3: overflow
        for (int i = 0; i < 9; i++) wr(TXD, 32'h50 + i);
        rd(STS, v);               chk("ovf_status", v, 32'hC08);
        wr(STS, 32'h800);
        rd(STS, v);               chk("ovf_cleared", v, 32'h408);

        // test 4: full + push + pop same cycle
        tx_ready = 1'b1;
        wr(TXD, 32'h60);
        rd(STS, v);               chk("full_push_pop", v, 32'h408);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", {24'b0, tx_data}, (i < 7) ? 32'h51 + i : 32'h60);
            step();
        end
        chk("drain_end_valid", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // test 5: CYCLE load and wrap
        wr(CYC, 32'hFFFF_FFFE);
`ifdef MEMSYS_CYCLE_CNT_EN
        exp_cyc = 32'hFFFF_FFFE;
`else
        exp_cyc = 32'h0;
`endif
        rd(CYC, v);               chk("cyc_loaded", v, exp_cyc);
        step(); step();
        rd(CYC, v);               chk("cyc_wrap", v, 32'h0);

        // test 6: reset mid-queue
        for (int i = 0; i < 5; i++) wr(TXD, 32'h70 + i);
        rd(STS, v);               chk("pre_reset_status", v, 32'h005);
        reset = 1'b0; #1;
        chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        rd(STS, v);               chk("reset_status", v, 32'h200);
        chk("reset_tx_data", {24'b0, tx_data}, 32'h0);
        @(negedge clk); reset = 1'b1;
        step();
        rd(32'h10, v);            chk("ram_kept", v, 32'hDEAD_BEEF);
        rd(CYC, v);               chk("cyc_after_reset_small", {31'b0, v > 32'd4}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
